// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises RX, samples each bit mid-period from the
// start-bit falling edge, and hands received bytes over with a ready/ack handshake.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clc,
  input  logic       res,
  input  logic       RX,
  input  logic       RECEIVER_ACK,
  output logic [7:0] MESSAGE,
  output logic       priznak_end_receiver,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             msg_q, msg_d;
  logic                   ready_q, ready_d;
  logic                   ovr_q, ovr_d;
  logic                   fe_q, fe_d;
  logic                   busy_q, busy_d;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], RX};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    msg_d   = msg_q;
    ready_d = RECEIVER_ACK ? 1'b0 : ready_q;
    ovr_d   = RECEIVER_ACK ? 1'b0 : ovr_q;
    fe_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            // A good stop always wins over a simultaneous ack.
            msg_d   = shift_q;
            ready_d = 1'b1;
            if (ready_q && !RECEIVER_ACK) ovr_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clc or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      msg_q   <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      msg_q   <= msg_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
    end
  end

  assign MESSAGE              = msg_q;
  assign priznak_end_receiver = ready_q;
  assign overrun              = ovr_q;
  assign frame_error          = fe_q;
  assign busy                 = busy_q;

endmodule
